nco_pwm_dac: RTL and testbench

//  Downstream stage of the NCO phase counter / sine-table SRAM: accepts signed 32-bit sine samples
//  (Q1.31, +/-(2^31-1)) over a valid/ready handshake and converts them to a single-bit PWM output
//  for an external RC filter. One-entry sample buffer; duty updated only at PWM period boundaries.

---
 rtl/nco_pkg.sv | 14 +
 rtl/nco_pwm_dac_if.sv | 13 +
 rtl/nco_lfsr16.sv | 20 ++
 rtl/nco_pwm_dac.sv | 102 ++++++++++
 tb/tb_nco_pwm_dac.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/nco_pkg.sv
// Shared constants and helpers for the NCO output stages (sample width, midscale, dither LFSR taps).
package nco_pkg;

  localparam int SAMPLE_W = 32;
  localparam int DUTY_MAX_W = 16;

  // Fibonacci LFSR feedback mask: taps 16,14,13,11 -> state bits 15,13,12,10.
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [DUTY_MAX_W-1:0] midscale(input int n);
    return 16'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/nco_pwm_dac_if.sv
// Sample stream from the sine-table SRAM into the PWM DAC.
interface nco_pwm_dac_if;

  // A sample moves only on a cycle where sample_valid and sample_ready are both high;
  // while valid is high and ready is low the producer holds sample_data unchanged.
  logic                          sample_valid;
  logic [nco_pkg::SAMPLE_W-1:0]  sample_data;
  logic                          sample_ready;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);

endinterface

// File: rtl/nco_lfsr16.sv
// 16-bit Fibonacci LFSR used for duty dithering; advances once per step pulse.
module nco_lfsr16
  import nco_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= seed;
    end else if (step) begin
      state <= {state[14:0], ^(state & LFSR_POLY)};
    end
  end

endmodule

// File: rtl/nco_pwm_dac.sv
// Signed sine samples -> single-bit PWM with a one-entry buffer; duty changes only at period wrap.
// Optional dither of the truncated fraction is enabled by defining NCO_DAC_DITHER_EN.
module nco_pwm_dac
  import nco_pkg::*;
#(
  parameter int          PWM_BITS  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  nco_pwm_dac_if.slave       smp,
  output logic               pwm_out,
  output logic               period_start,
  output logic               underrun,
  input  logic               underrun_clr
);

  localparam int FRAC_W = SAMPLE_W - PWM_BITS;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] cnt_next;
  logic [PWM_BITS-1:0] duty_act;
  logic [PWM_BITS-1:0] duty_act_next;
  logic [PWM_BITS-1:0] pend_duty;
  logic [PWM_BITS-1:0] duty_trunc;
  logic [PWM_BITS-1:0] duty_in;
  logic                pend_full;
  logic                accept;
  logic                boundary;

  assign smp.sample_ready = ~pend_full;
  assign accept           = smp.sample_valid & ~pend_full;
  assign boundary         = enable & (cnt == CNT_MAX);

  // Offset binary: flipping the sign bit maps -full..+full onto 0..2^N-1.
  assign duty_trunc = {~smp.sample_data[SAMPLE_W-1], smp.sample_data[SAMPLE_W-2:FRAC_W]};

`ifdef NCO_DAC_DITHER_EN
  logic [15:0]       lfsr_state;
  logic [FRAC_W-1:0] lfsr_ext;
  logic [FRAC_W:0]   frac_sum;

  nco_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (accept),
    .seed  (LFSR_SEED),
    .state (lfsr_state)
  );

  assign lfsr_ext = FRAC_W'(lfsr_state);
  assign frac_sum = {1'b0, smp.sample_data[FRAC_W-1:0]} + {1'b0, lfsr_ext};
  // A carry out of the fraction must not wrap full-scale duty back to zero.
  assign duty_in  = (&duty_trunc) ? duty_trunc : duty_trunc + PWM_BITS'(frac_sum[FRAC_W]);
`else
  logic unused_frac;
  logic unused_seed;

  assign duty_in     = duty_trunc;
  assign unused_frac = ^smp.sample_data[FRAC_W-1:0];
  assign unused_seed = ^LFSR_SEED;
`endif

  always_comb begin
    cnt_next      = enable ? cnt + PWM_BITS'(1) : cnt;
    duty_act_next = (boundary & pend_full) ? pend_duty : duty_act;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      duty_act     <= PWM_BITS'(midscale(PWM_BITS));
      pend_duty    <= '0;
      pend_full    <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      duty_act     <= duty_act_next;
      pwm_out      <= enable & (cnt_next < duty_act_next);
      period_start <= boundary & pend_full;

      // Accept needs an empty buffer and the pop needs a full one, so they never collide.
      if (boundary & pend_full) begin
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_full <= 1'b1;
        pend_duty <= duty_in;
      end

      if (boundary & ~pend_full) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nco_pwm_dac.sv
// Bench for nco_pwm_dac (default build, PWM_BITS=8): directed scenarios plus random traffic against a queue model.
module tb_nco_pwm_dac;

  localparam int N      = 8;
  localparam int PERIOD = 1 << N;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic underrun_clr = 1'b0;
  logic pwm_out;
  logic period_start;
  logic underrun;

  nco_pwm_dac_if smp_if ();

  nco_pwm_dac #(.PWM_BITS(N), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .smp          (smp_if),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: position within the period, active duty, one-deep pending queue.
  int          m_pos;
  int          m_duty;
  int          m_pend_q[$];
  bit          m_pwm, m_ps, m_und;
  logic [31:0] prod_q[$];
  int          hi_cnt, len_cnt, win_hi, per_duty;
  bit          per_valid;
  int          obs_log[$];
  int          len_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int to_duty(input logic [31:0] d);
    longint s;
    s = longint'($signed(d));
    return int'((s + 64'sd2147483648) / 64'sd16777216);
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_duty = PERIOD / 2;
    m_pend_q.delete();
    m_pwm = 1'b0;
    m_ps = 1'b0;
    m_und = 1'b0;
    per_valid = 1'b0;
    hi_cnt = 0;
    len_cnt = 0;
  endtask

  task automatic cyc(input bit en, input bit clr);
    bit was_full, bnd, acc;
    enable = en;
    underrun_clr = clr;
    smp_if.sample_valid = (prod_q.size() > 0);
    smp_if.sample_data = (prod_q.size() > 0) ? prod_q[0] : $urandom();
    @(posedge clk);
    was_full = (m_pend_q.size() > 0);
    bnd = en && (m_pos == PERIOD - 1);
    acc = smp_if.sample_valid && !was_full;
    m_ps = 1'b0;
    if (bnd && was_full) begin
      m_duty = m_pend_q.pop_front();
      m_ps = 1'b1;
    end
    if (bnd && !was_full) m_und = 1'b1;
    else if (clr) m_und = 1'b0;
    if (acc) m_pend_q.push_back(to_duty(prod_q.pop_front()));
    if (en) m_pos = (m_pos + 1) % PERIOD;
    m_pwm = en && (m_pos < m_duty);
    @(negedge clk);
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("period_start", 32'(period_start), 32'(m_ps));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("sample_ready", 32'(smp_if.sample_ready), 32'(m_pend_q.size() == 0));
    if (bnd) begin
      if (per_valid) begin
        chk("period_hi", 32'(hi_cnt), 32'(per_duty));
        obs_log.push_back(hi_cnt);
        len_log.push_back(len_cnt);
      end
      per_valid = 1'b1;
      per_duty = m_duty;
      hi_cnt = 0;
      len_cnt = 0;
    end
    hi_cnt += int'(pwm_out === 1'b1);
    win_hi += int'(pwm_out === 1'b1);
    len_cnt++;
  endtask

  task automatic run(input int n, input bit en = 1'b1);
    for (int i = 0; i < n; i++) cyc(en, 1'b0);
  endtask

  task automatic wait_ps(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
      cyc(1'b1, 1'b0);
      seen = (period_start === 1'b1);
    end
    if (!seen) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < 3 * PERIOD && m_pos != p; i++) cyc(1'b1, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pwm"}, 32'(pwm_out), 32'd0);
    chk({tag, "_ps"}, 32'(period_start), 32'd0);
    chk({tag, "_und"}, 32'(underrun), 32'd0);
    chk({tag, "_ready"}, 32'(smp_if.sample_ready), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    prod_q.delete();
    smp_if.sample_valid = 1'b0;
    #1;
    model_reset();
    check_reset_vals(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] corner [5];
    logic [31:0] d;
    corner[0] = 32'h7FFF_FFFF;
    corner[1] = 32'h8000_0000;
    corner[2] = 32'h8000_0001;
    corner[3] = 32'h0000_0000;
    corner[4] = 32'hFFFF_FFFF;
    smp_if.sample_valid = 1'b0;
    smp_if.sample_data = '0;
    model_reset();

    // Initial reset
    @(negedge clk);
    do_reset("rst0");

    // 1: no samples, midscale output, underrun at the first wrap
    win_hi = 0;
    run(PERIOD);
    chk("t1_hi", 32'(win_hi), 32'd128);
    chk("t1_und", 32'(underrun), 32'd1);
    cyc(1'b1, 1'b1);

    // 2: full-scale positive sample
    prod_q.push_back(32'h7FFF_FFFF);
    wait_ps("t2_ps_timeout");
    run(PERIOD);
    chk("t2_hi", 32'(obs_log[$]), 32'd255);

    // 3: back-to-back samples, second stalls until the boundary
    prod_q.push_back(32'h8000_0000);
    prod_q.push_back(32'h0000_0000);
    cyc(1'b1, 1'b0);
    chk("t3_stall_ready", 32'(smp_if.sample_ready), 32'd0);
    chk("t3_held", 32'(prod_q.size()), 32'd1);
    wait_ps("t3_ps_timeout");
    run(PERIOD);
    chk("t3_hi_min", 32'(obs_log[$]), 32'd0);
    run(PERIOD);
    chk("t3_hi_mid", 32'(obs_log[$]), 32'd128);
    chk("t3_no_loss", 32'(prod_q.size()), 32'd0);

    // 4: enable low for 10 cycles mid-period
    run_to_pos(50);
    win_hi = 0;
    run(10, 1'b0);
    chk("t4_pwm_low", 32'(win_hi), 32'd0);
    run_to_pos(0);
    chk("t4_len", 32'(len_log[$]), 32'(PERIOD + 10));

    // 5: reset at cnt=100 with a pending sample
    prod_q.push_back(32'h4000_0000);
    cyc(1'b1, 1'b0);
    run_to_pos(100);
    chk("t5_pend", 32'(smp_if.sample_ready), 32'd0);
    @(negedge clk);
    do_reset("t5_rst");
    win_hi = 0;
    run(PERIOD);
    chk("t5_hi_mid", 32'(win_hi), 32'd128);
    chk("t5_und", 32'(underrun), 32'd1);

    // 6: random traffic, enable gaps and clears
    for (int i = 0; i < 3000; i++) begin
      if (prod_q.size() < 2 && $urandom_range(0, 39) == 0) begin
        d = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom();
        prod_q.push_back(d);
      end
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 31) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
